// File: rtl/ubfly_pkg.sv
// Shared definitions for the unary butterfly array: run-controller state
// encoding, pipeline depth and the bit-reverse used to build twiddle streams.
package ubfly_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Product register, inner sum register, output register.
  localparam int LATENCY = 3;

  // Widest twiddle resolution the bit-reverse helper supports.
  localparam int MAX_BW = 16;

  // Reverses the low `width` bits of v; bits above `width` come back as zero.
  function automatic logic [MAX_BW-1:0] bit_rev(input logic [MAX_BW-1:0] v,
                                                input int               width);
    logic [MAX_BW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BW; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ubfly_lane.sv
// One bipolar unary radix-2 butterfly lane: XNOR multipliers against the
// internally generated twiddle bits, six scaled adders, a two-stage delay on
// the A inputs, and (with UBFLY_CNT_EN defined) four output ones-counters.
module ubfly_lane
  import ubfly_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int BINPUT   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      start_i,
  input  logic [BITWIDTH-1:0]       rev_i,
  input  logic [BITWIDTH-1:0]       w_re_i,
  input  logic [BITWIDTH-1:0]       w_im_i,
  input  logic                      ar_i,
  input  logic                      ai_i,
  input  logic                      br_i,
  input  logic                      bi_i,
`ifdef UBFLY_CNT_EN
  input  logic                      valid_i,
  output logic [4*(BITWIDTH+1)-1:0] cnt_o,
`endif
  output logic                      real0_o,
  output logic                      img0_o,
  output logic                      real1_o,
  output logic                      img1_o
);

  // Accumulator holds at most BINPUT-1 between cycles plus BINPUT new ones.
  localparam int ACC_W = $clog2(BINPUT) + 1;

  // Scaled add: returns {out_bit, next_acc}.
  function automatic logic [ACC_W:0] sadd(input logic [ACC_W-1:0] acc,
                                          input logic x,
                                          input logic y);
    logic [ACC_W-1:0] s;
    logic             o;
    s = acc + ACC_W'(x) + ACC_W'(y);
    o = (s >= ACC_W'(BINPUT));
    return {o, (o ? s - ACC_W'(BINPUT) : s)};
  endfunction

  logic             w_re_bit, w_im_bit;
  logic [3:0]       p_d, p_q;              // [0]=p1 [1]=p2 [2]=p3 [3]=p4
  logic             ar_d1_q, ai_d1_q, ar_d2_q, ai_d2_q;
  logic             re_d, im_d, re_q, im_q;
  logic [ACC_W-1:0] re_acc_d, im_acc_d, re_acc_q, im_acc_q;
  logic             start_d1_q;
  logic [3:0]       ox, oy, o_d, o_q;      // [0]=Real0 [1]=Img0 [2]=Real1 [3]=Img1
  logic [3:0][ACC_W-1:0] oacc_d, oacc_q;

  // Twiddle bit is one when the code exceeds the shared reversed counter.
  assign w_re_bit = (w_re_i > rev_i);
  assign w_im_bit = (w_im_i > rev_i);

  // Bipolar multiply is XNOR of data bit and twiddle bit.
  always_comb begin
    p_d[0] = ~(br_i ^ w_re_bit);
    p_d[1] = ~(br_i ^ w_im_bit);
    p_d[2] = ~(bi_i ^ w_re_bit);
    p_d[3] = ~(bi_i ^ w_im_bit);
  end

  // Stage 1: product register and first A delay.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      ar_d1_q <= 1'b0;
      ai_d1_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      ar_d1_q <= ar_i;
      ai_d1_q <= ai_i;
    end
  end

  // Inner sums: re = p1 - p4, im = p2 + p3; accumulators cleared so the first
  // valid product (arriving the cycle after start) sees an empty accumulator.
  // NOTE: every signal gets a value on every path through the block, so no
  // latch is inferred.
  always_comb begin
    {re_d, re_acc_d} = sadd(re_acc_q, p_q[0], ~p_q[3]);
    {im_d, im_acc_d} = sadd(im_acc_q, p_q[1], p_q[2]);
    if (clr_i || start_i) begin
      re_acc_d = '0;
      im_acc_d = '0;
    end
  end

  // Stage 2: inner sum register and second A delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q       <= 1'b0;
      im_q       <= 1'b0;
      re_acc_q   <= '0;
      im_acc_q   <= '0;
      ar_d2_q    <= 1'b0;
      ai_d2_q    <= 1'b0;
      start_d1_q <= 1'b0;
    end else begin
      re_q       <= re_d;
      im_q       <= im_d;
      re_acc_q   <= re_acc_d;
      im_acc_q   <= im_acc_d;
      ar_d2_q    <= ar_d1_q;
      ai_d2_q    <= ai_d1_q;
      start_d1_q <= start_i;
    end
  end

  // Output adders: X0 = A + W*B, X1 = A - W*B, cleared one cycle after the
  // inner adders to line up with the first valid inner sum.
  always_comb begin
    ox = {ai_d2_q, ar_d2_q, ai_d2_q, ar_d2_q};
    oy = {~im_q, ~re_q, im_q, re_q};
    o_d    = '0;
    oacc_d = '0;
    for (int i = 0; i < 4; i++) begin
      {o_d[i], oacc_d[i]} = sadd(oacc_q[i], ox[i], oy[i]);
    end
    if (clr_i || start_d1_q) oacc_d = '0;
  end

  // Stage 3: registered output bitstreams.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q    <= '0;
      oacc_q <= '0;
    end else begin
      o_q    <= o_d;
      oacc_q <= oacc_d;
    end
  end

  assign real0_o = o_q[0];
  assign img0_o  = o_q[1];
  assign real1_o = o_q[2];
  assign img1_o  = o_q[3];

`ifdef UBFLY_CNT_EN
  logic [3:0][BITWIDTH:0] cnt_q;

  // Ones-counters: cleared at window start, count only valid output bits,
  // then hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || start_i) begin
      cnt_q <= '0;
    end else if (valid_i) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_q[i] + (BITWIDTH+1)'(o_q[i]);
      end
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/ubutterfly_array.sv
// Array of NUM_BFLY unary bipolar butterflies under one run controller:
// twiddle capture, a 2^BITWIDTH-cycle window, pipeline drain and done pulse.
// Define UBFLY_CNT_EN to add per-output ones-counters and the oCnt port.
module ubutterfly_array
  import ubfly_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int NUM_BFLY = 4,
  parameter int BINPUT   = 2
) (
  input  logic                         iClk,
  input  logic                         iRstN,
  input  logic                         iClr,
  input  logic                         loadB,
  input  logic                         iStart,
  input  logic [NUM_BFLY-1:0]          iRealA,
  input  logic [NUM_BFLY-1:0]          iImgA,
  input  logic [NUM_BFLY-1:0]          iRealB,
  input  logic [NUM_BFLY-1:0]          iImgB,
  input  logic [NUM_BFLY*BITWIDTH-1:0] wReal,
  input  logic [NUM_BFLY*BITWIDTH-1:0] wImg,
  output logic [NUM_BFLY-1:0]          oReal0,
  output logic [NUM_BFLY-1:0]          oImg0,
  output logic [NUM_BFLY-1:0]          oReal1,
  output logic [NUM_BFLY-1:0]          oImg1,
  output logic                         oValid,
  output logic                         oBusy,
  output logic                         oDone
`ifdef UBFLY_CNT_EN
  ,
  output logic [NUM_BFLY*4*(BITWIDTH+1)-1:0] oCnt
`endif
);

  localparam int DW = $clog2(LATENCY);

  state_e                       state_q;
  logic [BITWIDTH-1:0]          c_q;
  logic [DW-1:0]                drain_q;
  logic                         busy_q, done_q, start_q;
  logic [LATENCY-1:0]           vld_q;
  logic [NUM_BFLY*BITWIDTH-1:0] w_re_q, w_im_q;
  logic [BITWIDTH-1:0]          rev;

  // Run controller with registered busy/done/start. Busy covers RUN and
  // DRAIN only, so it falls in the same cycle done pulses.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      c_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else if (iClr) begin
      state_q <= IDLE;
      c_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            state_q <= RUN;
            c_q     <= '0;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
          end
        end
        RUN: begin
          c_q <= c_q + BITWIDTH'(1);
          if (c_q == {BITWIDTH{1'b1}}) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          drain_q <= drain_q + DW'(1);
          if (drain_q == DW'(LATENCY - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Twiddle registers: captured only in IDLE, and iClr wins over loadB.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      w_re_q <= '0;
      w_im_q <= '0;
    end else if (!iClr && state_q == IDLE && loadB) begin
      w_re_q <= wReal;
      w_im_q <= wImg;
    end
  end

  // Valid tracks RUN through the lane pipeline depth.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      vld_q <= '0;
    end else if (iClr) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], (state_q == RUN)};
    end
  end

  // Bit-reversed counter gives a well-spread threshold sequence per window.
  assign rev = BITWIDTH'(bit_rev(MAX_BW'(c_q), BITWIDTH));

  assign oValid = vld_q[LATENCY-1];
  assign oBusy  = busy_q;
  assign oDone  = done_q;

  for (genvar k = 0; k < NUM_BFLY; k++) begin : g_lane
    ubfly_lane #(
      .BITWIDTH (BITWIDTH),
      .BINPUT   (BINPUT)
    ) u_lane (
      .clk      (iClk),
      .rst_n    (iRstN),
      .clr_i    (iClr),
      .start_i  (start_q),
      .rev_i    (rev),
      .w_re_i   (w_re_q[k*BITWIDTH +: BITWIDTH]),
      .w_im_i   (w_im_q[k*BITWIDTH +: BITWIDTH]),
      .ar_i     (iRealA[k]),
      .ai_i     (iImgA[k]),
      .br_i     (iRealB[k]),
      .bi_i     (iImgB[k]),
`ifdef UBFLY_CNT_EN
      .valid_i  (vld_q[LATENCY-1]),
      .cnt_o    (oCnt[k*4*(BITWIDTH+1) +: 4*(BITWIDTH+1)]),
`endif
      .real0_o  (oReal0[k]),
      .img0_o   (oImg0[k]),
      .real1_o  (oReal1[k]),
      .img1_o   (oImg1[k])
    );
  end

endmodule

// File: tb/tb_ubutterfly_array.sv
// Self-checking bench for ubutterfly_array (BITWIDTH=4, NUM_BFLY=4).
// A per-cycle algorithmic model pushes expected output bits into a queue as
// each input bit is driven; they are popped whenever oValid is high.
module tb_ubutterfly_array;

  localparam int BW  = 4;
  localparam int NB  = 4;
  localparam int WIN = 1 << BW;
  localparam int CW  = BW + 1;

  logic             iClk = 1'b0;
  logic             iRstN, iClr, loadB, iStart;
  logic [NB-1:0]    iRealA, iImgA, iRealB, iImgB;
  logic [NB*BW-1:0] wReal, wImg;
  logic [NB-1:0]    oReal0, oImg0, oReal1, oImg1;
  logic             oValid, oBusy, oDone;
`ifdef UBFLY_CNT_EN
  logic [NB*4*CW-1:0] oCnt;
`endif

  ubutterfly_array #(.BITWIDTH(BW), .NUM_BFLY(NB), .BINPUT(2)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .loadB(loadB), .iStart(iStart),
    .iRealA(iRealA), .iImgA(iImgA), .iRealB(iRealB), .iImgB(iImgB),
    .wReal(wReal), .wImg(wImg),
    .oReal0(oReal0), .oImg0(oImg0), .oReal1(oReal1), .oImg1(oImg1),
    .oValid(oValid), .oBusy(oBusy), .oDone(oDone)
`ifdef UBFLY_CNT_EN
    , .oCnt(oCnt)
`endif
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  logic [4*NB-1:0] exp_q[$];
  logic [NB-1:0]   ar_s[WIN], ai_s[WIN], br_s[WIN], bi_s[WIN];
  logic [BW-1:0]   mw_re[NB], mw_im[NB];   // twiddles the DUT should hold
  logic [BW-1:0]   nw_re[NB], nw_im[NB];   // twiddles to load next
  int              act_cnt[NB][4];
  int              exp_cnt[NB][4];

  // Lane-major bit view of the DUT outputs: Real0, Img0, Real1, Img1.
  function automatic logic [4*NB-1:0] pack_out();
    logic [4*NB-1:0] v;
    for (int l = 0; l < NB; l++) begin
      v[4*l+0] = oReal0[l];
      v[4*l+1] = oImg0[l];
      v[4*l+2] = oReal1[l];
      v[4*l+3] = oImg1[l];
    end
    return v;
  endfunction

  function automatic logic [BW-1:0] rev_bits(input int t);
    logic [BW-1:0] tv, r;
    tv = BW'(t);
    for (int i = 0; i < BW; i++) r[i] = tv[BW-1-i];
    return r;
  endfunction

  // Scaled add: out when acc + x + y reaches 2, returns {out, acc}.
  function automatic logic [2:0] sadd_m(input logic [1:0] acc, input logic x, input logic y);
    int s;
    s = int'(acc) + int'(x) + int'(y);
    if (s >= 2) return {1'b1, 2'(s - 2)};
    return {1'b0, 2'(s)};
  endfunction

  function automatic logic [15:0] balanced16();
    logic [15:0] v;
    logic        tmp;
    int          j;
    v = 16'h00FF;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = v[i]; v[i] = v[j]; v[j] = tmp;
    end
    return v;
  endfunction

  task automatic fill_random();
    for (int t = 0; t < WIN; t++) begin
      ar_s[t] = NB'($urandom);
      ai_s[t] = NB'($urandom);
      br_s[t] = NB'($urandom);
      bi_s[t] = NB'($urandom);
    end
  endtask

  task automatic drive_w();
    for (int l = 0; l < NB; l++) begin
      wReal[l*BW +: BW] = nw_re[l];
      wImg[l*BW +: BW]  = nw_im[l];
    end
  endtask

  // One window: start (optionally loading twiddles), drive 2^BW input bits,
  // score every valid output bit, then check framing.
  task automatic run_window(input bit do_load, input bit inject);
    logic [1:0]      acc_re[NB], acc_im[NB];
    logic [1:0]      acc_o[NB][4];
    logic [4*NB-1:0] got, expv;
    logic [BW-1:0]   rv;
    logic            wr, wi, p1, p2, p3, p4, re, im;
    int              first_v, nvalid, done_k;
    logic            busy0, busy_done;
    for (int l = 0; l < NB; l++) begin
      acc_re[l] = 2'd0;
      acc_im[l] = 2'd0;
      for (int j = 0; j < 4; j++) begin
        acc_o[l][j] = 2'd0;
        act_cnt[l][j] = 0;
        exp_cnt[l][j] = 0;
      end
    end
    first_v = -1; nvalid = 0; done_k = -1; busy0 = 1'b0; busy_done = 1'b1;
    @(negedge iClk);
    iStart = 1'b1;
    if (do_load) begin
      loadB = 1'b1;
      drive_w();
      for (int l = 0; l < NB; l++) begin
        mw_re[l] = nw_re[l];
        mw_im[l] = nw_im[l];
      end
    end
    for (int k = 0; k < 40 && done_k < 0; k++) begin
      @(negedge iClk);
      iStart = 1'b0;
      loadB  = 1'b0;
      if (k == 0) busy0 = oBusy;
      if (oValid) begin
        if (first_v < 0) first_v = k;
        nvalid++;
        got = pack_out();
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL data_extra: cycle %0d got=%h expected no valid output", k, got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            bad++;
            $display("FAIL data: cycle %0d got=%h exp=%h", k, got, expv);
          end
        end
        for (int l = 0; l < NB; l++)
          for (int j = 0; j < 4; j++) act_cnt[l][j] += int'(got[4*l+j]);
      end
      if (oDone) begin
        done_k    = k;
        busy_done = oBusy;
      end
      if (k < WIN) begin
        iRealA = ar_s[k]; iImgA = ai_s[k]; iRealB = br_s[k]; iImgB = bi_s[k];
        rv   = rev_bits(k);
        expv = '0;
        for (int l = 0; l < NB; l++) begin
          wr = (mw_re[l] > rv);
          wi = (mw_im[l] > rv);
          p1 = ~(br_s[k][l] ^ wr);
          p2 = ~(br_s[k][l] ^ wi);
          p3 = ~(bi_s[k][l] ^ wr);
          p4 = ~(bi_s[k][l] ^ wi);
          {re, acc_re[l]} = sadd_m(acc_re[l], p1, ~p4);
          {im, acc_im[l]} = sadd_m(acc_im[l], p2, p3);
          {expv[4*l+0], acc_o[l][0]} = sadd_m(acc_o[l][0], ar_s[k][l], re);
          {expv[4*l+1], acc_o[l][1]} = sadd_m(acc_o[l][1], ai_s[k][l], im);
          {expv[4*l+2], acc_o[l][2]} = sadd_m(acc_o[l][2], ar_s[k][l], ~re);
          {expv[4*l+3], acc_o[l][3]} = sadd_m(acc_o[l][3], ai_s[k][l], ~im);
          for (int j = 0; j < 4; j++) exp_cnt[l][j] += int'(expv[4*l+j]);
        end
        exp_q.push_back(expv);
      end else begin
        iRealA = NB'($urandom); iImgA = NB'($urandom);
        iRealB = NB'($urandom); iImgB = NB'($urandom);
      end
      if (inject && k == 5) begin
        iStart = 1'b1;
        loadB  = 1'b1;
        wReal  = ~wReal;
        wImg   = ~wImg;
      end
    end
    total++;
    if (first_v != 3) begin
      bad++; $display("FAIL latency: first oValid cycle=%0d exp=3", first_v);
    end
    total++;
    if (nvalid != WIN) begin
      bad++; $display("FAIL valid_len: got=%0d exp=%0d", nvalid, WIN);
    end
    total++;
    if (done_k != WIN + 3) begin
      bad++; $display("FAIL done_cycle: got=%0d exp=%0d", done_k, WIN + 3);
    end
    total++;
    if (busy0 !== 1'b1 || busy_done !== 1'b0) begin
      bad++; $display("FAIL busy: at_start=%b at_done=%b exp 1/0", busy0, busy_done);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover: %0d expected bits never produced", exp_q.size());
      exp_q.delete();
    end
`ifdef UBFLY_CNT_EN
    for (int l = 0; l < NB; l++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (int'(oCnt[(4*l+j)*CW +: CW]) != exp_cnt[l][j]) begin
          bad++;
          $display("FAIL cnt lane%0d out%0d: got=%0d exp=%0d", l, j, oCnt[(4*l+j)*CW +: CW], exp_cnt[l][j]);
        end
      end
`endif
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({pack_out(), oValid, oBusy, oDone} !== '0) begin
      bad++; $display("FAIL reset_outputs: got=%h exp=0", {pack_out(), oValid, oBusy, oDone});
    end
    repeat (2) @(negedge iClk);
    iRstN = 1'b1;
    repeat (2) @(negedge iClk);
    total++;
    if ({oValid, oBusy, oDone} !== 3'b000) begin
      bad++; $display("FAIL reset_idle: valid/busy/done=%b exp=000", {oValid, oBusy, oDone});
    end
    // Twiddle registers reset to 0: run without loading.
    for (int l = 0; l < NB; l++) begin mw_re[l] = '0; mw_im[l] = '0; end
    fill_random();
    run_window(1'b0, 1'b0);
  endtask

  task automatic test_w_zero();
    for (int l = 0; l < NB; l++) begin nw_re[l] = BW'(8); nw_im[l] = BW'(8); end
    for (int t = 0; t < WIN; t++) begin
      ar_s[t] = '1;
      ai_s[t] = '1;
      br_s[t] = NB'($urandom);
      bi_s[t] = br_s[t];
    end
    run_window(1'b1, 1'b0);
    // W = 0 and Br = Bi makes re exactly half ones, so Real0/Real1 = 12.
    for (int l = 0; l < NB; l++) begin
      total++;
      if (act_cnt[l][0] != 12 || act_cnt[l][2] != 12) begin
        bad++;
        $display("FAIL w_zero_count lane%0d: real0=%0d real1=%0d exp 12/12", l, act_cnt[l][0], act_cnt[l][2]);
      end
    end
  endtask

  task automatic test_w_one();
    logic [15:0] v;
    for (int l = 0; l < NB; l++) begin nw_re[l] = BW'(15); nw_im[l] = BW'(8); end
    for (int l = 0; l < NB; l++) begin
      v = balanced16(); for (int t = 0; t < WIN; t++) ar_s[t][l] = v[t];
      v = balanced16(); for (int t = 0; t < WIN; t++) ai_s[t][l] = v[t];
      v = balanced16(); for (int t = 0; t < WIN; t++) br_s[t][l] = v[t];
      v = balanced16(); for (int t = 0; t < WIN; t++) bi_s[t][l] = v[t];
    end
    run_window(1'b1, 1'b0);
  endtask

  task automatic test_mixed_lanes();
    nw_re[0] = 4'd0;  nw_re[1] = 4'd8; nw_re[2] = 4'd15; nw_re[3] = 4'd4;
    nw_im[0] = 4'd15; nw_im[1] = 4'd4; nw_im[2] = 4'd0;  nw_im[3] = 4'd8;
    fill_random();
    run_window(1'b1, 1'b0);
  endtask

  task automatic test_ignore_during_run();
    nw_re[0] = 4'd3; nw_re[1] = 4'd11; nw_re[2] = 4'd6;  nw_re[3] = 4'd13;
    nw_im[0] = 4'd9; nw_im[1] = 4'd2;  nw_im[2] = 4'd14; nw_im[3] = 4'd7;
    fill_random();
    run_window(1'b1, 1'b1);
    // Twiddles must still be the ones loaded at start.
    fill_random();
    run_window(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_window(1'b0, 1'b0);
    fill_random();
    run_window(1'b0, 1'b0);
  endtask

  task automatic test_clr_start();
    int seen;
    seen = 0;
    @(negedge iClk);
    iClr = 1'b1;
    iStart = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    iStart = 1'b0;
    total++;
    if (oBusy !== 1'b0) begin
      bad++; $display("FAIL clr_start_busy: got=%b exp=0", oBusy);
    end
`ifdef UBFLY_CNT_EN
    total++;
    if (oCnt !== '0) begin
      bad++; $display("FAIL clr_cnt: got=%h exp=0", oCnt);
    end
`endif
    for (int k = 0; k < 25; k++) begin
      @(negedge iClk);
      if (oValid || oBusy || oDone) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL clr_start_idle: active cycles=%0d exp=0", seen);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    seen = 0;
    fill_random();
    @(negedge iClk);
    iStart = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge iClk);
      iStart = 1'b0;
      iRealA = ar_s[k]; iImgA = ai_s[k]; iRealB = br_s[k]; iImgB = bi_s[k];
    end
    total++;
    if (oBusy !== 1'b1) begin
      bad++; $display("FAIL async_pre_busy: got=%b exp=1", oBusy);
    end
    #2;
    iRstN = 1'b0;
    #1;
    total++;
    if ({pack_out(), oValid, oBusy, oDone} !== '0) begin
      bad++; $display("FAIL async_reset_outputs: got=%h exp=0", {pack_out(), oValid, oBusy, oDone});
    end
    @(negedge iClk);
    iRstN = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge iClk);
      if (oValid || oBusy || oDone) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL async_no_done: active cycles=%0d exp=0", seen);
    end
    for (int l = 0; l < NB; l++) begin mw_re[l] = '0; mw_im[l] = '0; end
    fill_random();
    run_window(1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRstN = 1'b0; iClr = 1'b0; loadB = 1'b0; iStart = 1'b0;
    iRealA = '0; iImgA = '0; iRealB = '0; iImgB = '0;
    wReal = '0; wImg = '0;
    test_reset();
    test_w_zero();
    test_w_one();
    test_mixed_lanes();
    test_ignore_during_run();
    test_back_to_back();
    test_clr_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
